serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: streams two WIDTH-bit operands plus a carry-in through a
// single full_adder cell, LSB first, one bit per clock, behind a
// start/busy/done handshake.

// One-bit full adder cell used as the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c_in;
    assign carry = (a & b) | (c_in & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Counter holds 0..WIDTH so it never wraps inside an operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             cy_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] acc_next;

    full_adder u_full_adder (
        .a     (opa_reg[0]),
        .b     (opb_reg[0]),
        .c_in  (cy_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB; for a one-bit adder it is the whole word.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_next = fa_sum;
        end else begin : g_acc_wn
            assign acc_next = {fa_sum, acc_reg[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and serial datapath; all outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            opa_reg   <= '0;
            opb_reg   <= '0;
            acc_reg   <= '0;
            cy_reg    <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        opa_reg   <= a;
                        opb_reg   <= b;
                        cy_reg    <= c_in;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    opa_reg <= opa_reg >> 1;
                    opb_reg <= opb_reg >> 1;
                    acc_reg <= acc_next;
                    cy_reg  <= fa_carry;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_BIT) begin
                        sum_reg   <= acc_next;
                        c_out_reg <= fa_carry;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign c_out = c_out_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1: drivers push the
// expected {c_out,sum} at acceptance, monitors pop and compare on done.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       s8_start, s8_cin, s8_busy, s8_done, s8_cout;
    logic [7:0] s8_a, s8_b, s8_sum;
    logic       s1_start, s1_cin, s1_busy, s1_done, s1_cout;
    logic [0:0] s1_a, s1_b, s1_sum;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b),
        .c_in(s8_cin), .busy(s8_busy), .done(s8_done), .sum(s8_sum), .c_out(s8_cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b),
        .c_in(s1_cin), .busy(s1_busy), .done(s1_done), .sum(s1_sum), .c_out(s1_cout)
    );

    typedef struct {
        logic [8:0] exp;
        int         acc_cyc;
    } exp8_t;

    typedef struct {
        logic [1:0] exp;
        int         acc_cyc;
    } exp1_t;

    exp8_t q8[$];
    exp1_t q1[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    logic [8:0] hold8;
    logic [1:0] hold1;
    logic       prev_done8, prev_done1;

    // WIDTH=8 monitor: result/latency on done, stability and pulse width otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset8", {28'd0, s8_busy, s8_done, s8_cout, |s8_sum}, 32'd0);
            hold8      <= '0;
            prev_done8 <= 1'b0;
        end else begin
            if (prev_done8) check("done_width8", {31'd0, s8_done}, 32'd0);
            if (s8_done) begin
                if (q8.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done8: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp8_t e;
                    e = q8.pop_front();
                    check("result8", {23'd0, s8_cout, s8_sum}, {23'd0, e.exp});
                    check("latency8", cyc - e.acc_cyc, 32'd8);
                    check("busy_at_done8", {31'd0, s8_busy}, 32'd0);
                    $display("W8 done: {c_out,sum}=%03h expected %03h", {s8_cout, s8_sum}, e.exp);
                    hold8 <= e.exp;
                end
            end else begin
                check("hold8", {23'd0, s8_cout, s8_sum}, {23'd0, hold8});
            end
            prev_done8 <= s8_done;
        end
    end

    // WIDTH=1 monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold1      <= '0;
            prev_done1 <= 1'b0;
        end else begin
            if (prev_done1) check("done_width1", {31'd0, s1_done}, 32'd0);
            if (s1_done) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done1: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp1_t e;
                    e = q1.pop_front();
                    check("result1", {30'd0, s1_cout, s1_sum}, {30'd0, e.exp});
                    check("latency1", cyc - e.acc_cyc, 32'd1);
                    hold1 <= e.exp;
                end
            end else begin
                check("hold1", {30'd0, s1_cout, s1_sum}, {30'd0, hold1});
            end
            prev_done1 <= s1_done;
        end
    end

    // ---------------- drivers ----------------
    // Wait (bounded) for a negedge where the DUT is idle; returns 0 on timeout.
    task automatic wait_idle8(output bit ok);
        int t = 0;
        @(negedge clk);
        while ((s8_busy || s8_done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 100);
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout8: got busy after 100 cycles expected idle");
        end
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          input logic [8:0] exp, output int acc_cyc);
        bit    ok;
        exp8_t e;
        acc_cyc = -1;
        wait_idle8(ok);
        if (ok) begin
            s8_a = av; s8_b = bv; s8_cin = ci; s8_start = 1'b1;
            @(posedge clk);
            #1;
            e.exp = exp;
            e.acc_cyc = cyc;
            acc_cyc = cyc;
            q8.push_back(e);
            check("busy_after_accept8", {31'd0, s8_busy}, 32'd1);
            s8_start = 1'b0;
            // Scramble inputs: the operation must use the captured values.
            s8_a = ~av; s8_b = ~bv; s8_cin = ~ci;
        end
    endtask

    task automatic issue1(input logic av, input logic bv, input logic ci);
        int    t = 0;
        exp1_t e;
        @(negedge clk);
        while ((s1_busy || s1_done) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout1: got busy after 20 cycles expected idle");
        end else begin
            s1_a = av; s1_b = bv; s1_cin = ci; s1_start = 1'b1;
            @(posedge clk);
            #1;
            e.exp = {1'b0, av} + {1'b0, bv} + {1'b0, ci};
            e.acc_cyc = cyc;
            q1.push_back(e);
            s1_start = 1'b0;
            s1_a = ~av; s1_b = ~bv; s1_cin = ~ci;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         ac, prev_ac;
        bit         ok;
        logic [7:0] ra, rb;
        logic       rc;
        logic [7:0] hv_a[3] = '{8'h12, 8'h80, 8'h0F};
        logic [7:0] hv_b[3] = '{8'h34, 8'h80, 8'hF0};
        logic       hv_c[3] = '{1'b1, 1'b0, 1'b1};
        logic [8:0] hv_e[3] = '{9'h047, 9'h100, 9'h100};

        rst_n = 1'b0;
        s8_start = 0; s8_a = 0; s8_b = 0; s8_cin = 0;
        s1_start = 0; s1_a = 0; s1_b = 0; s1_cin = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Basic add with busy checked across every RUN edge.
        issue8(8'h5A, 8'h3C, 1'b0, 9'h096, ac);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1 check("busy_run8", {31'd0, s8_busy}, 32'd1);
        end

        // Carry out, then all-ones with carry-in; previous result held meanwhile.
        issue8(8'hFF, 8'h01, 1'b0, 9'h100, ac);
        issue8(8'hFF, 8'hFF, 1'b1, 9'h1FF, ac);

        // start held high; operands perturbed mid-RUN; ops spaced 10 edges apart.
        prev_ac = 0;
        for (int i = 0; i < 3; i++) begin
            wait_idle8(ok);
            if (ok) begin
                s8_a = hv_a[i]; s8_b = hv_b[i]; s8_cin = hv_c[i]; s8_start = 1'b1;
                @(posedge clk);
                #1;
                begin
                    exp8_t e;
                    e.exp = hv_e[i];
                    e.acc_cyc = cyc;
                    q8.push_back(e);
                end
                if (i > 0) check("b2b_spacing8", cyc - prev_ac, 32'd10);
                prev_ac = cyc;
                repeat (3) @(negedge clk);
                s8_a = 8'hA5; s8_b = 8'h5A; s8_cin = 1'b1;
            end
        end
        s8_start = 1'b0;

        // Asynchronous reset in the middle of a run.
        issue8(8'h77, 8'h11, 1'b0, 9'h088, ac);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset8", {28'd0, s8_busy, s8_done, s8_cout, |s8_sum}, 32'd0);
        q8.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue8(8'h77, 8'h11, 1'b0, 9'h088, ac);

        // Random sweeps, both widths in parallel.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    rc = 1'($urandom);
                    issue8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, ac);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    issue1(1'($urandom), 1'($urandom), 1'($urandom));
                end
            end
        join

        // Drain scoreboards (bounded).
        for (int t = 0; t < 200 && (q8.size() != 0 || q1.size() != 0); t++) @(posedge clk);
        if (q8.size() != 0 || q1.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending ops expected 0", q8.size(), q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
